audio_frame_buffer: RTL and testbench

Consumes stereo sample pairs from the I2S receive stage, mixes each pair to a signed mono sample, and packs consecutive samples into ping-pong frame banks of FRAME_LEN entries. The spectrum/visualizer stage downstream reads a completed frame by address while the next frame fills, and releases it with a done pulse. A per-frame peak magnitude and a saturating overrun counter are produced alongside each frame.

---
 rtl/audio_frame_buffer.sv | 115 +++++++++++
 tb/tb_audio_frame_buffer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/audio_frame_buffer.sv
// Mixes stereo I2S pairs to mono and packs them into ping-pong frame banks
// with per-frame peak magnitude and a saturating overrun counter.
module audio_frame_buffer #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned SAMPLE_WIDTH = 16,
    parameter int unsigned FRAME_LEN    = 256,
    localparam int unsigned ADDR_WIDTH  = $clog2(FRAME_LEN)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_WIDTH-1:0]   data_left,
    input  logic [DATA_WIDTH-1:0]   data_right,
    input  logic                    sample_valid,
    output logic                    frame_ready,
    output logic                    frame_bank,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [SAMPLE_WIDTH-1:0] rd_data,
    input  logic                    frame_done,
    output logic [SAMPLE_WIDTH-1:0] frame_peak,
    output logic [7:0]              overrun_count
);

    localparam int unsigned SUM_WIDTH = DATA_WIDTH + 1;
    localparam logic [SAMPLE_WIDTH-1:0] MOST_NEG = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};
    localparam logic [SAMPLE_WIDTH-1:0] MOST_POS = {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
    localparam logic [ADDR_WIDTH-1:0]   LAST_PTR = ADDR_WIDTH'(FRAME_LEN - 1);

    // |s| with the most negative code clamped to the most positive one
    function automatic logic [SAMPLE_WIDTH-1:0] magnitude(input logic [SAMPLE_WIDTH-1:0] s);
        if (!s[SAMPLE_WIDTH-1]) return s;
        if (s == MOST_NEG)      return MOST_POS;
        return SAMPLE_WIDTH'(-s);
    endfunction

    logic [SAMPLE_WIDTH-1:0] mem [2*FRAME_LEN];

    logic                    s1_valid;
    logic [SAMPLE_WIDTH-1:0] s1_sample;
    logic                    wb;
    logic [ADDR_WIDTH-1:0]   wr_ptr;
    logic [SAMPLE_WIDTH-1:0] run_pk;

    logic [SUM_WIDTH-1:0]    sum_c;
    logic [SAMPLE_WIDTH-1:0] mix_c;
    logic [SAMPLE_WIDTH-1:0] s1_mag_c;
    logic [SAMPLE_WIDTH-1:0] peak_c;
    logic                    last_c;
    logic                    complete_c;
    logic                    bank_free_c;

    // avg = sum >>> 1 fits in DATA_WIDTH bits, so avg[DW-1 -: SW] is sum[DW -: SW]
    always_comb begin
        sum_c       = {data_left[DATA_WIDTH-1], data_left} + {data_right[DATA_WIDTH-1], data_right};
        mix_c       = sum_c[DATA_WIDTH -: SAMPLE_WIDTH];
        s1_mag_c    = magnitude(s1_sample);
        peak_c      = (s1_mag_c > run_pk) ? s1_mag_c : run_pk;
        last_c      = (wr_ptr == LAST_PTR);
        complete_c  = s1_valid && last_c;
        bank_free_c = !frame_ready || frame_done;
    end

    // Stage 1: register the mixed sample and its write enable
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_sample <= '0;
        end else begin
            s1_valid <= sample_valid;
            if (sample_valid) s1_sample <= mix_c;
        end
    end

    // Stage 2: pointer/peak update, frame completion, release and overrun
    always_ff @(posedge clk) begin
        if (reset) begin
            wb            <= 1'b0;
            wr_ptr        <= '0;
            run_pk        <= '0;
            frame_ready   <= 1'b0;
            frame_bank    <= 1'b1;
            frame_peak    <= '0;
            overrun_count <= '0;
        end else begin
            if (s1_valid) begin
                if (last_c) begin
                    wr_ptr <= '0;
                    run_pk <= '0;
                    if (bank_free_c) begin
                        frame_bank  <= wb;
                        wb          <= ~wb;
                        frame_ready <= 1'b1;
                        frame_peak  <= peak_c;
                    end else if (overrun_count != 8'hFF) begin
                        overrun_count <= overrun_count + 8'd1;
                    end
                end else begin
                    wr_ptr <= ADDR_WIDTH'(wr_ptr + 1'b1);
                    run_pk <= peak_c;
                end
            end
            if (frame_done && frame_ready && !complete_c) frame_ready <= 1'b0;
        end
    end

    // Sample storage; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (s1_valid && !reset) mem[{wb, wr_ptr}] <= s1_sample;
    end

    always_ff @(posedge clk) begin
        if (reset) rd_data <= '0;
        else       rd_data <= mem[{frame_bank, rd_addr}];
    end

endmodule

// File: tb/tb_audio_frame_buffer.sv
// Directed plus randomized bench for audio_frame_buffer against a frame-level reference model.
module tb_audio_frame_buffer;

    localparam int unsigned DW = 32;
    localparam int unsigned SW = 16;
    localparam int unsigned FL = 4;
    localparam int unsigned AW = $clog2(FL);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] data_left = '0;
    logic [DW-1:0] data_right = '0;
    logic          sample_valid = 1'b0;
    logic          frame_ready;
    logic          frame_bank;
    logic [AW-1:0] rd_addr = '0;
    logic [SW-1:0] rd_data;
    logic          frame_done = 1'b0;
    logic [SW-1:0] frame_peak;
    logic [7:0]    overrun_count;

    int n_err = 0;
    int n_checks = 0;

    // Reference model state
    logic [SW-1:0] mem_m [2][FL];
    logic [SW-1:0] cur_q [$];
    bit            m_ready;
    bit            m_bank;
    bit            m_wb;
    int            m_peak;
    int            m_ovr;

    audio_frame_buffer #(.DATA_WIDTH(DW), .SAMPLE_WIDTH(SW), .FRAME_LEN(FL)) dut (
        .clk(clk), .reset(reset),
        .data_left(data_left), .data_right(data_right), .sample_valid(sample_valid),
        .frame_ready(frame_ready), .frame_bank(frame_bank),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .frame_done(frame_done), .frame_peak(frame_peak), .overrun_count(overrun_count)
    );

    always #5 clk = ~clk;

    // Floor of (L+R)/2 scaled down to SW bits, as plain integer arithmetic
    function automatic logic [SW-1:0] ref_mix(input logic [DW-1:0] l, input logic [DW-1:0] r);
        longint sum;
        sum = longint'($signed(l)) + longint'($signed(r));
        sum = sum >>> (DW - SW + 1);
        return sum[SW-1:0];
    endfunction

    function automatic int ref_mag(input logic [SW-1:0] s);
        int v;
        v = int'($signed(s));
        if (v < 0) v = -v;
        if (v > 32767) v = 32767;
        return v;
    endfunction

    task automatic model_reset();
        cur_q.delete();
        m_ready = 0; m_bank = 1; m_wb = 0; m_peak = 0; m_ovr = 0;
    endtask

    task automatic model_sample(input logic [SW-1:0] s, input bit done);
        mem_m[m_wb][cur_q.size()] = s;
        cur_q.push_back(s);
        if (cur_q.size() == FL) begin
            if (!m_ready || done) begin
                m_bank = m_wb; m_wb = !m_wb; m_ready = 1; m_peak = 0;
                foreach (cur_q[i]) if (ref_mag(cur_q[i]) > m_peak) m_peak = ref_mag(cur_q[i]);
            end else if (m_ovr < 255) begin
                m_ovr++;
            end
            cur_q.delete();
        end else if (done && m_ready) begin
            m_ready = 0;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".ready"},   32'(frame_ready),   32'(m_ready));
        check({tag, ".bank"},    32'(frame_bank),    32'(m_bank));
        check({tag, ".peak"},    32'(frame_peak),    32'(m_peak));
        check({tag, ".overrun"}, 32'(overrun_count), 32'(m_ovr));
        if (m_ready) begin
            for (int a = 0; a < FL; a++) begin
                rd_addr = AW'(a);
                @(posedge clk); #1;
                check($sformatf("%s.rd%0d", tag, a), 32'(rd_data), 32'(mem_m[m_bank][a]));
            end
        end
    endtask

    task automatic send_one(input logic [DW-1:0] l, input logic [DW-1:0] r, input bit done);
        @(posedge clk); #1;
        data_left = l; data_right = r; sample_valid = 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0; frame_done = done;
        @(posedge clk); #1;
        frame_done = 1'b0;
        model_sample(ref_mix(l, r), done);
    endtask

    task automatic stream(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            data_left = $urandom; data_right = $urandom; sample_valid = 1'b1;
            model_sample(ref_mix(data_left, data_right), 1'b0);
        end
        @(posedge clk); #1;
        sample_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic release_frame();
        @(posedge clk); #1;
        frame_done = 1'b1;
        @(posedge clk); #1;
        frame_done = 1'b0;
        if (m_ready) m_ready = 0;
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset.rd_data", 32'(rd_data), 32'h0);
        reset = 1'b0;
        check_state("reset");

        // Frame of identical samples; ready exactly two cycles after last strobe
        for (int i = 0; i < 3; i++) send_one(32'h4000_0000, 32'h4000_0000, 1'b0);
        @(posedge clk); #1;
        data_left = 32'h4000_0000; data_right = 32'h4000_0000; sample_valid = 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        check("t1.ready_early", 32'(frame_ready), 32'h0);
        @(posedge clk); #1;
        check("t1.ready_on_time", 32'(frame_ready), 32'h1);
        model_sample(ref_mix(32'h4000_0000, 32'h4000_0000), 1'b0);
        check_state("t1");
        check("t1.peak_abs", 32'(frame_peak), 32'h4000);
        release_frame();
        check_state("t1.released");

        // Full-scale extremes and saturated magnitude
        send_one(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
        send_one(32'h8000_0000, 32'h8000_0000, 1'b0);
        send_one(32'h0000_0000, 32'h0000_0000, 1'b0);
        send_one(32'h0000_0000, 32'h0000_0000, 1'b0);
        check_state("t2");
        check("t2.peak_abs", 32'(frame_peak), 32'h7FFF);
        release_frame();

        // Arithmetic shift and truncation; frame stays held afterwards
        send_one(32'h0001_0000, 32'hFFFF_0000, 1'b0);
        send_one(32'h0003_0000, 32'h0000_0000, 1'b0);
        send_one(32'hFFFE_0000, 32'h0000_0000, 1'b0);
        send_one(32'h1234_5678, 32'h0102_0304, 1'b0);
        check_state("t3");

        // Three overruns while held
        stream(3 * FL);
        check_state("t4");
        check("t4.overrun_abs", 32'(overrun_count), 32'd3);

        // Release coincident with completion
        for (int i = 0; i < 3; i++) send_one($urandom, $urandom, 1'b0);
        send_one($urandom, $urandom, 1'b1);
        check_state("t5");

        // Random streams with random releases
        for (int k = 0; k < 20; k++) begin
            stream($urandom_range(1, 9));
            if ($urandom_range(0, 1) == 1) release_frame();
            check_state($sformatf("rnd%0d", k));
        end

        // Overrun saturation
        if (!m_ready) stream(FL - cur_q.size());
        stream(300 * FL);
        check_state("t6");
        check("t6.saturated", 32'(overrun_count), 32'd255);

        // Reset mid-frame, then a fresh frame
        send_one(32'h7000_0000, 32'h7000_0000, 1'b0);
        send_one(32'h7000_0000, 32'h7000_0000, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        model_reset();
        check("t7.rd_data", 32'(rd_data), 32'h0);
        reset = 1'b0;
        check_state("t7.reset");
        send_one(32'h0100_0000, 32'h0100_0000, 1'b0);
        send_one(32'hFF00_0000, 32'hFF00_0000, 1'b0);
        send_one(32'h0200_0000, 32'h0000_0000, 1'b0);
        send_one(32'h0000_0000, 32'h0000_0000, 1'b0);
        check_state("t7");
        check("t7.peak_abs", 32'(frame_peak), 32'h0100);
        release_frame();

        // Reset while a stage-1 sample is in flight drops that sample
        @(posedge clk); #1;
        data_left = 32'h5555_0000; data_right = 32'h5555_0000; sample_valid = 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        stream(FL);
        check_state("t8");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
